// File: rtl/sar_pkg.sv
// Shared definitions for the 10-bit successive-approximation control FSM.
// Holds the controller state encoding, default build parameters and the
// counter/index widths those defaults imply.
package sar_pkg;

    // Controller states. IDLE must stay first so that a zeroed state register
    // always means "no conversion in progress".
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SET    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_t;

    // Default build: 10-bit result, 2 track cycles, 15 WAIT cycles per bit
    // before a missing comparator answer is forced to 0.
    localparam int SAR_N             = 10;
    localparam int SAR_SAMPLE_CYCLES = 2;
    localparam int SAR_TIMEOUT       = 15;

    // Widths for the default build. The FSM derives the same quantities from
    // its own parameters so that non-default builds size correctly.
    localparam int SAR_IDX_W  = $clog2(SAR_N);
    localparam int SAR_SCNT_W = $clog2(SAR_SAMPLE_CYCLES + 1);
    localparam int SAR_TCNT_W = $clog2(SAR_TIMEOUT + 1);

endpackage : sar_pkg

// File: rtl/sar_fsm_10b.sv
// Purpose : SAR ADC control FSM; samples, then binary-searches N bits through
//           the comparator (trial code on dac_code, one comp_en per bit).
// Latency : start edge to data_valid = SAMPLE_CYCLES + sum(1 + k_bit) + 1
//           cycles, k_bit = WAIT cycles until comp_done (23 with 1-cycle
//           comparator and defaults).
// Backpressure: none accepted; start outside IDLE is dropped, and a silent
//           comparator is bounded by TIMEOUT per bit (bit forced to 0).
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   start           conversion request, only honoured in IDLE
//   comp_result     comparator decision (1 = input >= trial code)
//   comp_done       comparator decision valid, only consumed in WAIT
//   sample_en       track/hold control, high for SAMPLE_CYCLES cycles
//   dac_code        trial code to the comparator, 0 outside SET/WAIT
//   comp_en         one-cycle comparison request (SET state)
//   busy            high from leaving IDLE until returning to IDLE
//   data_out        last completed result, held until the next DONE
//   data_valid      one-cycle strobe in DONE
//   timeout_err     sticky bit-timeout flag, cleared by an accepted start
module sar_fsm_10b
    import sar_pkg::*;
#(
    parameter int N             = SAR_N,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
    parameter int TIMEOUT       = SAR_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         comp_result,
    input  logic         comp_done,
    output logic         sample_en,
    output logic [N-1:0] dac_code,
    output logic         comp_en,
    output logic         busy,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         timeout_err
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int SCNT_W = $clog2(SAMPLE_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] ONE = N'(1);

    sar_state_t        state;
    logic [N-1:0]      result;     // bits resolved so far, trial bit excluded
    logic [IDX_W-1:0]  idx;        // bit currently under trial
    logic [SCNT_W-1:0] scnt;       // cycles spent in SAMPLE
    logic [TCNT_W-1:0] tcnt;       // cycles spent in WAIT for the current bit

    // Decision-side helpers. Outputs are registered, so the code for the
    // next SET is built here from the decision being taken this cycle.
    logic [N-1:0]      trial_bit;
    logic [N-1:0]      next_trial_bit;
    logic [N-1:0]      result_dec;
    logic [IDX_W-1:0]  idx_dec;
    logic              tmo_hit;

    always_comb begin
        trial_bit      = ONE << idx;
        idx_dec        = idx - IDX_W'(1);
        next_trial_bit = ONE << idx_dec;
        // Only the trial bit is ever OR-ed in, so no carry can ripple.
        result_dec     = (comp_done && comp_result) ? (result | trial_bit) : result;
        // The TIMEOUT-th WAIT cycle still accepts a late comp_done; only when
        // it is absent in that cycle is the bit forced.
        tmo_hit        = (tcnt == TCNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            result      <= '0;
            idx         <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            sample_en   <= 1'b0;
            dac_code    <= '0;
            comp_en     <= 1'b0;
            busy        <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Single-cycle strobes fall back unless a branch re-asserts them.
            comp_en    <= 1'b0;
            data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    dac_code  <= '0;
                    sample_en <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        state       <= ST_SAMPLE;
                        result      <= '0;
                        scnt        <= '0;
                        timeout_err <= 1'b0;
                        idx         <= IDX_W'(N - 1);
                        sample_en   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    if (scnt == SCNT_W'(SAMPLE_CYCLES - 1)) begin
                        // Enter SET with the MSB trial already on the bus.
                        state     <= ST_SET;
                        sample_en <= 1'b0;
                        dac_code  <= result | trial_bit;
                        comp_en   <= 1'b1;
                        tcnt      <= '0;
                    end else begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end

                ST_SET: begin
                    // comp_done seen here belongs to no request; ignore it.
                    state <= ST_WAIT;
                    tcnt  <= '0;
                end

                ST_WAIT: begin
                    if (comp_done || tmo_hit) begin
                        result <= result_dec;
                        if (!comp_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (idx == '0) begin
                            state      <= ST_DONE;
                            data_out   <= result_dec;
                            data_valid <= 1'b1;
                            dac_code   <= '0;
                        end else begin
                            state    <= ST_SET;
                            idx      <= idx_dec;
                            dac_code <= result_dec | next_trial_bit;
                            comp_en  <= 1'b1;
                            tcnt     <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // data_out/data_valid were loaded on entry; busy drops
                    // together with the return to IDLE.
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    dac_code <= '0;
                end

                default: begin
                    state      <= ST_IDLE;
                    sample_en  <= 1'b0;
                    dac_code   <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule : sar_fsm_10b
